// File: rtl/m68k_arb_pkg.sv
// Shared types for the 68000 bus arbiter.
// State encodings are visible to software through the status register.
package m68k_arb_pkg;

   localparam int ARB_W             = 3;
   localparam int GRANT_TIMEOUT_DEF = 16;

   typedef enum logic [ARB_W-1:0] {
      OWN_IDLE   = 3'd0,
      OWN_BUSY   = 3'd1,
      GRANT_PEND = 3'd2,
      GRANTED    = 3'd3,
      FOREIGN    = 3'd4,
      RECLAIM    = 3'd5
   } arb_state_t;

endpackage

// File: rtl/pistorm_sync.sv
// N-stage synchroniser for one asynchronous input.
// The reset value matches the pin's idle level.
module pistorm_sync #(
   parameter int   N       = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [N-1:0] sr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr <= {N{RST_VAL}};
      end else begin
         sr <= {sr[N-2:0], d};
      end
   end

   assign q = sr[N-1];

endmodule

// File: rtl/m68k_bus_arbiter.sv
// 68000 bus ownership FSM: Pi cycle gating and BR/BG/BGACK handover.
// Everything runs on PI_CLK; the 68K clock is seen only as c7m_fall.
module m68k_bus_arbiter
   import m68k_arb_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int GRANT_TIMEOUT = GRANT_TIMEOUT_DEF,
   parameter int TO_W          = 5
) (
   input  logic             PI_CLK,
   input  logic             PI_RST,
   input  logic             M68K_CLK,
   input  logic             M68K_BR_n,
   input  logic             M68K_BGACK_n,
   output logic             M68K_BG_n,
   input  logic             pi_req,
   output logic             pi_ack,
   output logic             eng_start,
   input  logic             eng_busy,
   output logic             bus_owned,
   output logic             grant_to,
   input  logic             grant_to_clr,
   output logic [ARB_W-1:0] arb_state
);

   localparam logic [TO_W-1:0] TO_MAX  = TO_W'(GRANT_TIMEOUT);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(GRANT_TIMEOUT - 1);

   logic br_n_s, bgack_n_s, c7m_s1, c7m_s2;
   logic br, bgack, c7m_fall;

   arb_state_t      state_q, state_d;
   logic            bg_n_q, bg_n_d;
   logic            own_q, own_d;
   logic            ack_q, ack_d;
   logic            gto_q, gto_d, to_set;
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic [1:0]      guard_q, guard_d;

   pistorm_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_br_sync (
      .clk (PI_CLK),
      .rst (PI_RST),
      .d   (M68K_BR_n),
      .q   (br_n_s)
   );

   pistorm_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_bgack_sync (
      .clk (PI_CLK),
      .rst (PI_RST),
      .d   (M68K_BGACK_n),
      .q   (bgack_n_s)
   );

   pistorm_sync #(.N(2), .RST_VAL(1'b0)) u_c7m_sync (
      .clk (PI_CLK),
      .rst (PI_RST),
      .d   (M68K_CLK),
      .q   (c7m_s1)
   );

   assign br       = ~br_n_s;
   assign bgack    = ~bgack_n_s;
   assign c7m_fall = c7m_s2 & ~c7m_s1;

   always_ff @(posedge PI_CLK or posedge PI_RST) begin
      if (PI_RST) begin
         state_q <= OWN_IDLE;
         bg_n_q  <= 1'b1;
         own_q   <= 1'b1;
         ack_q   <= 1'b0;
         gto_q   <= 1'b0;
         cnt_q   <= '0;
         guard_q <= '0;
         c7m_s2  <= 1'b0;
      end else begin
         state_q <= state_d;
         bg_n_q  <= bg_n_d;
         own_q   <= own_d;
         ack_q   <= ack_d;
         gto_q   <= gto_d;
         cnt_q   <= cnt_d;
         guard_q <= guard_d;
         c7m_s2  <= c7m_s1;
      end
   end

   always_comb begin
      state_d = state_q;
      bg_n_d  = bg_n_q;
      own_d   = own_q;
      ack_d   = 1'b0;
      cnt_d   = cnt_q;
      guard_d = guard_q;
      to_set  = 1'b0;
      unique case (state_q)
         OWN_IDLE: begin
            if (br) begin
               state_d = GRANT_PEND;
            end else if (pi_req) begin
               ack_d   = 1'b1;
               guard_d = 2'd2;
               state_d = OWN_BUSY;
            end
         end
         OWN_BUSY: begin
            // eng_busy is not trusted until the engine has seen eng_start
            if (guard_q != 2'd0) begin
               guard_d = guard_q - 2'd1;
            end else if (!eng_busy) begin
               state_d = br ? GRANT_PEND : OWN_IDLE;
            end
         end
         GRANT_PEND: begin
            if (!br) begin
               state_d = OWN_IDLE;
            end else if (c7m_fall) begin
               bg_n_d  = 1'b0;
               own_d   = 1'b0;
               cnt_d   = '0;
               state_d = GRANTED;
            end
         end
         GRANTED: begin
            if (bgack) begin
               state_d = FOREIGN;
            end else if (!br) begin
               state_d = RECLAIM;
            end else if (c7m_fall) begin
               if (cnt_q == TO_LAST) begin
                  cnt_d   = TO_MAX;
                  to_set  = 1'b1;
                  bg_n_d  = 1'b1;
                  state_d = RECLAIM;
               end else begin
                  cnt_d = cnt_q + TO_W'(1);
               end
            end
         end
         FOREIGN: begin
            if (c7m_fall) begin
               bg_n_d = 1'b1;
            end
            if (!bgack) begin
               state_d = RECLAIM;
            end
         end
         RECLAIM: begin
            // BG_n only moves on a 68K falling edge, so release lands here
            if (c7m_fall) begin
               bg_n_d  = 1'b1;
               own_d   = 1'b1;
               state_d = br ? GRANT_PEND : OWN_IDLE;
            end
         end
         default: begin
            state_d = OWN_IDLE;
         end
      endcase
      gto_d = grant_to_clr ? 1'b0 : (to_set | gto_q);
   end

   assign M68K_BG_n = bg_n_q;
   assign bus_owned = own_q;
   assign pi_ack    = ack_q;
   assign eng_start = ack_q;
   assign grant_to  = gto_q;
   assign arb_state = state_q;

endmodule

// File: tb/tb_m68k_bus_arbiter.sv
// Scoreboard bench: scenarios queue the expected sequence of output changes,
// a monitor pops one entry every time the observed output bundle changes.
`timescale 1ns/1ps
module tb_m68k_bus_arbiter;
   import m68k_arb_pkg::*;

   logic       PI_CLK = 1'b0;
   logic       M68K_CLK = 1'b0;
   logic       PI_RST;
   logic       M68K_BR_n, M68K_BGACK_n, M68K_BG_n;
   logic       pi_req, pi_ack, eng_start, eng_busy;
   logic       bus_owned, grant_to, grant_to_clr;
   logic [2:0] arb_state;

   typedef struct packed {
      logic [2:0] st;
      logic       bg_n;
      logic       own;
      logic       gto;
      logic       ack;
      logic       start;
   } snap_t;

   snap_t exp_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;
   int    c7_falls = 0;
   bit    mon_on = 1'b0;

   m68k_bus_arbiter dut (
      .PI_CLK       (PI_CLK),
      .PI_RST       (PI_RST),
      .M68K_CLK     (M68K_CLK),
      .M68K_BR_n    (M68K_BR_n),
      .M68K_BGACK_n (M68K_BGACK_n),
      .M68K_BG_n    (M68K_BG_n),
      .pi_req       (pi_req),
      .pi_ack       (pi_ack),
      .eng_start    (eng_start),
      .eng_busy     (eng_busy),
      .bus_owned    (bus_owned),
      .grant_to     (grant_to),
      .grant_to_clr (grant_to_clr),
      .arb_state    (arb_state)
   );

   always #5 PI_CLK = ~PI_CLK;
   always #71 M68K_CLK = ~M68K_CLK;
   always @(negedge M68K_CLK) c7_falls++;

   function automatic snap_t mk(input int st, input logic bg, input logic own,
                                input logic gto, input logic ack);
      snap_t s;
      s.st    = 3'(st);
      s.bg_n  = bg;
      s.own   = own;
      s.gto   = gto;
      s.ack   = ack;
      s.start = ack;
      return s;
   endfunction

   function automatic snap_t cur_snap();
      snap_t s;
      s.st    = arb_state;
      s.bg_n  = M68K_BG_n;
      s.own   = bus_owned;
      s.gto   = grant_to;
      s.ack   = pi_ack;
      s.start = eng_start;
      return s;
   endfunction

   function automatic string fmt(input snap_t s);
      return $sformatf("st=%0d bg_n=%b own=%b gto=%b ack=%b start=%b",
                       s.st, s.bg_n, s.own, s.gto, s.ack, s.start);
   endfunction

   task automatic push(input int st, input logic bg, input logic own,
                       input logic gto, input logic ack);
      exp_q.push_back(mk(st, bg, own, gto, ack));
   endtask

   task automatic check_now(input string name, input snap_t e);
      snap_t c;
      c = cur_snap();
      n_cmp++;
      if (c !== e) begin
         n_bad++;
         $display("FAIL %s: got %s, required %s", name, fmt(c), fmt(e));
      end
   endtask

   task automatic bound_fail(input string name, input string what);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout waiting for %s (st=%0d bg_n=%b)",
               name, what, arb_state, M68K_BG_n);
   endtask

   task automatic wait_state(input string name, input int s, input int max);
      for (int i = 0; i < max; i++) begin
         @(negedge PI_CLK);
         if (arb_state == 3'(s)) return;
      end
      bound_fail(name, $sformatf("arb_state=%0d", s));
   endtask

   task automatic wait_ack(input string name, input int max);
      for (int i = 0; i < max; i++) begin
         @(negedge PI_CLK);
         if (pi_ack === 1'b1) return;
      end
      bound_fail(name, "pi_ack");
   endtask

   task automatic wait_bg_high(input string name, input int max);
      for (int i = 0; i < max; i++) begin
         @(negedge PI_CLK);
         if (M68K_BG_n === 1'b1) return;
      end
      bound_fail(name, "BG_n high");
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge PI_CLK);
   endtask

   // monitor: every change of the output bundle consumes one expectation
   initial begin
      snap_t prev, cur, e;
      prev = mk(0, 1'b1, 1'b1, 1'b0, 1'b0);
      wait (mon_on);
      forever begin
         @(negedge PI_CLK);
         cur = cur_snap();
         if (cur !== prev) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_event: got %s, required no change",
                        fmt(cur));
            end else begin
               e = exp_q.pop_front();
               if (cur !== e) begin
                  n_bad++;
                  $display("FAIL event: got %s, required %s", fmt(cur), fmt(e));
               end
            end
            prev = cur;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int f0;
      PI_RST       = 1'b1;
      M68K_BR_n    = 1'b1;
      M68K_BGACK_n = 1'b1;
      pi_req       = 1'b0;
      eng_busy     = 1'b0;
      grant_to_clr = 1'b0;
      cycles(3);
      check_now("reset", mk(0, 1, 1, 0, 0));
      PI_RST = 1'b0;
      mon_on = 1'b1;
      cycles(3);

      // two plain Pi cycles, one ack each
      for (int k = 0; k < 2; k++) begin
         push(1, 1, 1, 0, 1);
         push(1, 1, 1, 0, 0);
         push(0, 1, 1, 0, 0);
         pi_req = 1'b1;
         wait_ack("s1_ack", 10);
         pi_req   = 1'b0;
         eng_busy = 1'b1;
         cycles(5);
         eng_busy = 1'b0;
         wait_state("s1_idle", 0, 10);
         cycles(3);
      end

      // br mid-cycle: the engine cycle finishes before any grant
      push(1, 1, 1, 0, 1);
      push(1, 1, 1, 0, 0);
      push(2, 1, 1, 0, 0);
      push(3, 0, 0, 0, 0);
      push(5, 0, 0, 0, 0);
      push(0, 1, 1, 0, 0);
      pi_req = 1'b1;
      wait_ack("s2_ack", 10);
      pi_req   = 1'b0;
      eng_busy = 1'b1;
      cycles(2);
      M68K_BR_n = 1'b0;
      cycles(8);
      check_now("s2_busy_hold", mk(1, 1, 1, 0, 0));
      eng_busy = 1'b0;
      wait_state("s2_grant", 3, 60);
      M68K_BR_n = 1'b1;
      wait_state("s2_idle", 0, 60);
      cycles(3);

      // full handover to a foreign master and back
      push(2, 1, 1, 0, 0);
      push(3, 0, 0, 0, 0);
      push(4, 0, 0, 0, 0);
      push(4, 1, 0, 0, 0);
      push(5, 1, 0, 0, 0);
      push(0, 1, 1, 0, 0);
      M68K_BR_n = 1'b0;
      wait_state("s3_grant", 3, 60);
      M68K_BGACK_n = 1'b0;
      wait_bg_high("s3_bg_rel", 60);
      M68K_BR_n = 1'b1;
      cycles(4);
      M68K_BGACK_n = 1'b1;
      wait_state("s3_idle", 0, 60);
      cycles(3);

      // grant never acknowledged: timeout after 16 68K falling edges
      push(2, 1, 1, 0, 0);
      push(3, 0, 0, 0, 0);
      push(5, 1, 0, 1, 0);
      push(0, 1, 1, 1, 0);
      push(0, 1, 1, 0, 0);
      M68K_BR_n = 1'b0;
      wait_state("s4_grant", 3, 60);
      f0 = c7_falls;
      wait_state("s4_timeout", 5, 400);
      n_cmp++;
      if (c7_falls - f0 != 16) begin
         n_bad++;
         $display("FAIL s4_fall_count: got %0d, required 16", c7_falls - f0);
      end
      M68K_BR_n = 1'b1;
      wait_state("s4_idle", 0, 60);
      grant_to_clr = 1'b1;
      cycles(1);
      grant_to_clr = 1'b0;
      cycles(2);
      check_now("s4_clr", mk(0, 1, 1, 0, 0));

      // br and pi_req reach the FSM together (BR_n leads by the sync depth)
      push(2, 1, 1, 0, 0);
      push(3, 0, 0, 0, 0);
      push(4, 0, 0, 0, 0);
      push(4, 1, 0, 0, 0);
      push(5, 1, 0, 0, 0);
      push(0, 1, 1, 0, 0);
      push(1, 1, 1, 0, 1);
      push(1, 1, 1, 0, 0);
      push(0, 1, 1, 0, 0);
      M68K_BR_n = 1'b0;
      cycles(2);
      pi_req = 1'b1;
      wait_state("s5_grant", 3, 60);
      M68K_BGACK_n = 1'b0;
      wait_bg_high("s5_bg_rel", 60);
      M68K_BR_n = 1'b1;
      cycles(4);
      M68K_BGACK_n = 1'b1;
      wait_ack("s5_ack", 100);
      pi_req   = 1'b0;
      eng_busy = 1'b1;
      cycles(4);
      eng_busy = 1'b0;
      wait_state("s5_idle", 0, 20);
      cycles(3);

      // reset while a foreign master holds the bus
      push(2, 1, 1, 0, 0);
      push(3, 0, 0, 0, 0);
      push(4, 0, 0, 0, 0);
      push(0, 1, 1, 0, 0);
      M68K_BR_n = 1'b0;
      wait_state("s6_grant", 3, 60);
      M68K_BGACK_n = 1'b0;
      wait_state("s6_foreign", 4, 20);
      #2;
      PI_RST       = 1'b1;
      M68K_BR_n    = 1'b1;
      M68K_BGACK_n = 1'b1;
      #1;
      check_now("s6_rst_async", mk(0, 1, 1, 0, 0));
      cycles(3);
      PI_RST = 1'b0;
      cycles(20);
      check_now("s6_no_ack", mk(0, 1, 1, 0, 0));

      cycles(5);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL leftover_events: got %0d pending, required 0",
                  exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
